// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: replays a host-written table of I2C transactions into the master controller.
// Define SEQ_TIMEOUT_EN to abort a run when any handshake wait exceeds TIMEOUT_CYCLES.
module i2c_txn_sequencer #(
    parameter int DEPTH          = 8,
    parameter int AW             = 3,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_idx,
    input  logic          cfg_rw,
    input  logic [6:0]    cfg_addr,
    input  logic [31:0]   cfg_data,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] rd_idx,
    output logic          m_enable,
    output logic [6:0]    m_addr,
    output logic [31:0]   m_data,
    output logic          m_rw,
    input  logic          m_ready,
    input  logic [7:0]    m_data_out
);
    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT_ACCEPT, WAIT_DONE, GAP, FINISH} state_t;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state_q;
    logic [39:0]   tbl_q [DEPTH];
    logic [AW-1:0] idx_q;
    logic [AW:0]   n_q;
    logic [AW:0]   idx_nx;
    logic [GW-1:0] gap_q;
    logic          rdy_meta_q;
    logic          rdy_s_q;
    logic          busy_q;
    logic          done_q;
    logic          rd_valid_q;
    logic [7:0]    rd_data_q;
    logic [AW-1:0] rd_idx_q;
    logic          m_enable_q;
    logic [6:0]    m_addr_q;
    logic [31:0]   m_data_q;
    logic          m_rw_q;
    logic          accept;
    logic          stay;
    logic          abort;
    logic          tmo_hit;

    assign accept = start && state_q == IDLE;
    // WAIT_ACCEPT waits for ready low; LOAD and WAIT_DONE wait for ready high
    assign stay   = state_q inside {LOAD, WAIT_ACCEPT, WAIT_DONE} && rdy_s_q == (state_q == WAIT_ACCEPT);
    assign abort  = stay && tmo_hit;
    assign idx_nx = {1'b0, idx_q} + (AW+1)'(1);

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_idx   = rd_idx_q;
    assign m_enable = m_enable_q;
    assign m_addr   = m_addr_q;
    assign m_data   = m_data_q;
    assign m_rw     = m_rw_q;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign err     = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= stay ? tmo_q + TW'(1) : '0;
            err_q <= accept ? 1'b0 : err_q | abort;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) tbl_q[cfg_idx] <= {cfg_rw, cfg_addr, cfg_data};
    end

    // m_ready comes from the bit-level engine and is resynchronised before use
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= m_ready;
            rdy_s_q    <= rdy_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
            m_enable_q <= 1'b0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            m_rw_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            if (abort) begin
                m_enable_q <= 1'b0;
                state_q    <= FINISH;
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        n_q     <= len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : len;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= len == '0 ? FINISH : LOAD;
                    end
                    LOAD: begin
                        {m_rw_q, m_addr_q, m_data_q} <= tbl_q[idx_q];
                        if (rdy_s_q) begin
                            m_enable_q <= 1'b1;
                            state_q    <= REQ;
                        end
                    end
                    REQ: state_q <= WAIT_ACCEPT;
                    // enable must drop before the master's post-data ACK so it issues STOP
                    WAIT_ACCEPT: if (!rdy_s_q) begin
                        m_enable_q <= 1'b0;
                        state_q    <= WAIT_DONE;
                    end
                    WAIT_DONE: if (rdy_s_q) begin
                        rd_valid_q <= m_rw_q;
                        if (m_rw_q) begin
                            rd_data_q <= m_data_out;
                            rd_idx_q  <= idx_q;
                        end
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
                    GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        gap_q <= '0;
                        if (idx_nx < n_q) begin
                            idx_q   <= idx_nx[AW-1:0];
                            state_q <= LOAD;
                        end else begin
                            state_q <= FINISH;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                    FINISH: begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
- Upstream command stage for the I2C master controller.
- Holds a small host-written table of I2C transactions (rw, 7-bit address, 32-bit write data).
- On `start`, replays entries 0..len-1 in order, driving the master's enable/addr/data_in/rw and pacing on its `ready`.
- Returns each read byte on a valid-qualified result port tagged with its table index, for sensor-init and polling sequences.

Parameters:
- DEPTH, 8, number of table entries; must be a power of two ≥ 2.
- AW, 3, table index width; log2(DEPTH).
- GAP_CYCLES, 16, clk cycles of forced idle between consecutive transactions (bus free time); minimum 1.
- TIMEOUT_CYCLES, 65535, clk cycles allowed per wait state before abort; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, same clock that feeds the master.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  AW  table entry to write.
- cfg_rw  in  1  entry direction: 1 = read, 0 = write.
- cfg_addr  in  7  entry slave address.
- cfg_data  in  32  entry write data, MSB sent first.
- start  in  1  single-cycle pulse that runs the table.
- len  in  AW+1  number of entries to run, sampled on start.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  sticky abort flag; cleared on the next accepted start.
- rd_valid  out  1  one-cycle pulse; a read result is present.
- rd_data  out  8  read byte.
- rd_idx  out  AW  table index of the read.
- m_enable  out  1  to master enable.
- m_addr  out  7  to master addr.
- m_data  out  32  to master data_in.
- m_rw  out  1  to master rw.
- m_ready  in  1  from master ready; treated as asynchronous.
- m_data_out  in  8  from master data_out; stable once m_ready has returned high.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; m_addr/m_data/m_rw 0.
  - State IDLE; index 0.
  - Table contents are not reset.
  - rst mid-transaction drops m_enable immediately; the master is reset by the same rst.
- m_ready passes through a 2-flop synchronizer (rdy_s) before any use. All handshake waits use rdy_s.
- Table:
  - One entry per cycle, written when cfg_we=1 and busy=0.
  - cfg_we while busy=1 is ignored.
- start:
  - Accepted only in IDLE; ignored while busy.
  - On acceptance: latch n = min(len, DEPTH), clear err, set idx=0, busy=1.
- States:
  - IDLE: on accepted start, go to LOAD if n>0, else FINISH.
  - LOAD:
    - Register m_addr/m_data/m_rw from entry[idx]; these hold stable until the next LOAD.
    - Go to REQ if rdy_s=1; otherwise stay (waits for the master to become idle).
  - REQ: m_enable=1; go to WAIT_ACCEPT.
  - WAIT_ACCEPT:
    - Hold m_enable=1 until rdy_s=0 (master accepted).
    - Then m_enable=0 and go to WAIT_DONE.
    - m_enable must be low before the master's ACK-after-data state, so that a STOP is generated.
  - WAIT_DONE:
    - On rdy_s=1: if m_rw=1, pulse rd_valid with rd_data=m_data_out and rd_idx=idx.
    - Then go to GAP.
  - GAP:
    - Count GAP_CYCLES clk cycles.
    - Then idx+1; go to LOAD if idx+1<n, else FINISH.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Latency: rd_valid follows the master's ready rising by 3 clk cycles (2 synchronizer cycles + 1 registered).
- Master NACK: the master returns to idle without indication. The sequencer treats this as completion; a read byte is reported as-is.
- Boundaries:
  - len=0 → done 2 cycles after start, no m_enable activity.
  - len>DEPTH → clamped to DEPTH.
  - idx never wraps within one run.
  - start coincident with cfg_we in IDLE: the table write happens and the start is accepted; the write is visible to LOAD.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A per-state counter runs in LOAD, WAIT_ACCEPT and WAIT_DONE, reset on each state entry.
  - Reaching TIMEOUT_CYCLES:
    - m_enable=0 and err=1;
    - no rd_valid for that entry;
    - go to FINISH, so remaining entries are skipped and done pulses.
- Not defined: no counter logic; the wait states wait indefinitely; err is tied 0.

Test Plan:
- Write entry0 = {rw0, 0x50, 0xA5A5_0F0F}, start len=1, master model completes → m_enable rises 2 cycles after start and falls after ready low; done pulses once; rd_valid never asserts.
- Entries 0..2 = write/read/write, read byte 0x3C, len=3 → transactions issued in order with ≥GAP_CYCLES idle between them; exactly one rd_valid with rd_data=0x3C, rd_idx=1; done after the third transaction.
- start with len=0 → done 2 cycles later; busy high for 1 cycle; m_enable stays 0.
- len=12 with DEPTH=8 → exactly 8 transactions; second start pulse during busy ignored; cfg_we during busy leaves the table unchanged (read back via a later run).
- Assert rst while in WAIT_ACCEPT → m_enable/busy/done/rd_valid 0 immediately; a new start after release runs from idx 0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, m_ready stuck high → after 100 cycles in WAIT_ACCEPT: err=1, done pulses, m_enable 0; next start clears err.
